// File: rtl/bus_pkg.sv
// Shared constants for the bus FIFO driver: default width, Z helper, err bit indices,
// and the occupancy states that the FIFO count walks through.
package bus_pkg;

   localparam int BUS_WIDTH_DEF = 8;

   // Replicate this to build an all-Z bus of any width.
   localparam logic Z_BIT = 1'bz;

   localparam int ERR_OVF = 0;
   localparam int ERR_UDF = 1;

   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } occ_e;

endpackage

// File: rtl/tristate_drv.sv
// Combinational tri-state driver: passes i_in to o_out when i_en is high, else all-Z.
// Zero latency; no backpressure.
module tristate_drv
   import bus_pkg::*;
#(
   parameter int WIDTH = BUS_WIDTH_DEF
)(
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_in,
   output tri   [WIDTH-1:0] o_out
);

   assign o_out = i_en ? i_in : {WIDTH{Z_BIT}};

endmodule

// File: rtl/bus_fifo_driver.sv
// Small synchronous FIFO whose head word is driven onto a shared tri-state bus when read_en
// selects it (zero-latency drive, pop at the edge). Define BUS_FIFO_ERR_EN for sticky err[1:0].
module bus_fifo_driver
   import bus_pkg::*;
#(
   parameter int WIDTH = BUS_WIDTH_DEF,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             read_en,
   output tri   [WIDTH-1:0] bus_out,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
`ifdef BUS_FIFO_ERR_EN
   ,
   output logic [1:0]       err
`endif
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   occ_e             w_occ;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic             w_drv;
   logic [WIDTH-1:0] w_head;

   always_comb begin
      w_occ = OCC_PARTIAL;
      if (r_count == '0) begin
         w_occ = OCC_EMPTY;
      end else if (r_count == DEPTH_C) begin
         w_occ = OCC_FULL;
      end
   end

   assign w_full  = (w_occ == OCC_FULL);
   assign w_empty = (w_occ == OCC_EMPTY);

   // Full/empty are pre-edge views, so push-on-full is dropped even when a pop frees a slot.
   assign w_push = wr_en & ~w_full;
   assign w_pop  = read_en & ~w_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + (AW+1)'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !reset) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   assign w_head = r_mem[r_rd_ptr];
   assign w_drv  = w_pop;

   tristate_drv #(
      .WIDTH (WIDTH)
   ) u_drv (
      .i_en  (w_drv),
      .i_in  (w_head),
      .o_out (bus_out)
   );

   assign full  = w_full;
   assign empty = w_empty;
   assign count = r_count;

`ifdef BUS_FIFO_ERR_EN
   logic [1:0] r_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_err <= '0;
      end else begin
         if (wr_en && w_full) begin
            r_err[ERR_OVF] <= 1'b1;
         end
         if (read_en && w_empty) begin
            r_err[ERR_UDF] <= 1'b1;
         end
      end
   end

   assign err = r_err;
`endif

endmodule
